// File: rtl/dma_pkg.sv
// dma_pkg: shared types for the DMA command sequencer.
package dma_pkg;

  localparam int SLOT_W = 3;
  localparam int DESC_W = 128;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GAP,
    S_ISSUE,
    S_WAIT,
    S_NEXT,
    S_DONE
  } seq_state_t;

  // Slot index doubles as the DMA operation code.
  typedef enum logic [2:0] {
    OP_INF = 3'd0,
    OP_FMI = 3'd1,
    OP_KEX = 3'd2,
    OP_KPW = 3'd3,
    OP_KDW = 3'd4,
    OP_FMO = 3'd5
  } op_code_t;

  typedef struct packed {
    logic [31:0] y_mem;
    logic [31:0] ty;
    logic [31:0] x_mem;
    logic [31:0] tx;
  } tile_desc_t;

endpackage

// File: rtl/seq_desc_table.sv
// seq_desc_table: per-slot tile descriptor register file.
// One gated write port (out-of-range slots dropped), asynchronous read by slot.
module seq_desc_table
  import dma_pkg::*;
#(
  parameter int N_SLOTS = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_we,
  input  logic [SLOT_W-1:0] i_waddr,
  input  logic [DESC_W-1:0] i_wdata,
  input  logic [SLOT_W-1:0] i_raddr,
  output tile_desc_t        o_rdata
);

  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(N_SLOTS - 1);

  tile_desc_t r_mem [N_SLOTS];

  // Descriptor storage: cleared on reset, written only for valid slots.
  // NOTE: this table must come up all-zero, so it sits on the async reset
  // like any other register; non-blocking updates keep every flop consistent.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_SLOTS; i++) r_mem[i] <= '0;
    end else if (i_we && (i_waddr <= LAST_SLOT)) begin
      r_mem[i_waddr] <= tile_desc_t'(i_wdata);
    end
  end

  assign o_rdata = (i_raddr <= LAST_SLOT) ? r_mem[i_raddr] : '0;

endmodule

// File: rtl/dma_op_sequencer.sv
// dma_op_sequencer: walks the enabled DMA operation slots in ascending order,
// issuing op code + tile descriptor with an s_op pulse and waiting for a fresh
// rising edge of e_op before moving on.
// Optional watchdog in WAIT: define DMA_SEQ_TIMEOUT_EN.
module dma_op_sequencer
  import dma_pkg::*;
#(
  parameter int N_OPS   = 6,
  parameter int GAP_CYC = 2,
  parameter int SOP_CYC = 3,
  parameter int TO_CYC  = 65535
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [N_OPS-1:0]  op_en,
  input  logic              cfg_we,
  input  logic [SLOT_W-1:0] cfg_idx,
  input  logic [DESC_W-1:0] cfg_data,
  input  logic              e_op,
  output logic              s_op,
  output logic [2:0]        op,
  output logic [31:0]       tx_i,
  output logic [31:0]       ty_i,
  output logic [31:0]       x_mem_i,
  output logic [31:0]       y_mem_i,
  output logic              busy,
  output logic              done,
  output logic              err
);

  seq_state_t        r_state, w_next;
  logic [N_OPS-1:0]  r_en_q;
  logic [SLOT_W-1:0] r_cur;
  logic [15:0]       r_cnt;
  logic              r_e_op_d;
  logic              r_s_op, r_busy, r_done;
  op_code_t          r_op;
  tile_desc_t        r_desc, w_rd_desc;
  logic              w_first_vld, w_next_vld, w_e_rise, w_start_ok, w_load;
  logic [SLOT_W-1:0] w_first_idx, w_next_idx, w_rd_slot;
`ifdef DMA_SEQ_TIMEOUT_EN
  logic [31:0]       r_to_cnt;
  logic              r_err, w_to_hit;
`endif

  // Table writes are only honoured while no sequence is running.
  seq_desc_table #(.N_SLOTS(N_OPS)) u_table (
    .clk     (clk),
    .rst_n   (rst),
    .i_we    (cfg_we & ~r_busy),
    .i_waddr (cfg_idx),
    .i_wdata (cfg_data),
    .i_raddr (w_rd_slot),
    .o_rdata (w_rd_desc)
  );

  assign w_e_rise   = e_op & ~r_e_op_d;
  assign w_start_ok = (r_state == S_IDLE) & start;
  // IDLE looks up the first slot of the new run; NEXT looks up the following one.
  assign w_rd_slot  = (r_state == S_IDLE) ? w_first_idx : w_next_idx;

  // Slot search: lowest enabled slot overall, and lowest latched slot above r_cur.
  always_comb begin
    w_first_vld = 1'b0;
    w_first_idx = '0;
    w_next_vld  = 1'b0;
    w_next_idx  = '0;
    for (int i = N_OPS - 1; i >= 0; i--) begin
      if (op_en[i]) begin
        w_first_vld = 1'b1;
        w_first_idx = SLOT_W'(i);
      end
      if (r_en_q[i] && (SLOT_W'(i) > r_cur)) begin
        w_next_vld = 1'b1;
        w_next_idx = SLOT_W'(i);
      end
    end
  end

  // Next-state decode and descriptor load strobe.
  // NOTE: every output of this block is given a default first so no path
  // through the case leaves a variable unassigned (which would infer a latch).
  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          // An empty run settles through NEXT so done lands two cycles after start.
          w_next = w_first_vld ? S_GAP : S_NEXT;
          w_load = w_first_vld;
        end
      end
      S_GAP:   if (r_cnt == 16'(GAP_CYC - 1)) w_next = S_ISSUE;
      S_ISSUE: if (r_cnt == 16'(SOP_CYC - 1)) w_next = S_WAIT;
      S_WAIT: begin
        if (w_e_rise) w_next = S_NEXT;
`ifdef DMA_SEQ_TIMEOUT_EN
        else if (w_to_hit) w_next = S_DONE;
`endif
      end
      S_NEXT: begin
        w_next = w_next_vld ? S_GAP : S_DONE;
        w_load = w_next_vld;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // Per-state cycle counter and e_op history for edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt    <= '0;
      r_e_op_d <= 1'b0;
    end else begin
      r_cnt    <= (w_next != r_state) ? '0 : r_cnt + 16'd1;
      r_e_op_d <= e_op;
    end
  end

  // Registered outputs, latched enables and the active descriptor.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s_op <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_en_q <= '0;
      r_cur  <= '0;
      r_op   <= OP_INF;
      r_desc <= '0;
    end else begin
      r_s_op <= (w_next == S_ISSUE);
      r_busy <= (w_next != S_IDLE);
      r_done <= (w_next == S_DONE);
      if (w_start_ok) r_en_q <= op_en;
      if (w_load) begin
        r_cur  <= w_rd_slot;
        r_op   <= op_code_t'(w_rd_slot);
        r_desc <= w_rd_desc;
      end
    end
  end

`ifdef DMA_SEQ_TIMEOUT_EN
  assign w_to_hit = (r_state == S_WAIT) & ~w_e_rise & (r_to_cnt == 32'(TO_CYC - 1));

  // Watchdog: counts cycles spent in WAIT; err is sticky until the next start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_to_cnt <= '0;
      r_err    <= 1'b0;
    end else begin
      r_to_cnt <= ((r_state == S_WAIT) && (w_next == S_WAIT)) ? r_to_cnt + 32'd1 : '0;
      if (w_start_ok)    r_err <= 1'b0;
      else if (w_to_hit) r_err <= 1'b1;
    end
  end

  assign err = r_err;
`else
  // No watchdog in this build: err is constant low.
  assign err = (TO_CYC < 0);
`endif

  assign s_op    = r_s_op;
  assign op      = r_op;
  assign tx_i    = r_desc.tx;
  assign ty_i    = r_desc.ty;
  assign x_mem_i = r_desc.x_mem;
  assign y_mem_i = r_desc.y_mem;
  assign busy    = r_busy;
  assign done    = r_done;

endmodule

// File: tb/tb_dma_op_sequencer.sv
// tb_dma_op_sequencer: randomized self-checking bench. The reference model is
// the descriptor table contents plus the list of enabled slots; timing
// expectations come from the latency rules (start->s_op, e_op->s_op, done).
module tb_dma_op_sequencer;

  localparam int GAP    = 2;
  localparam int SOP    = 3;
  localparam int TB_TO  = 20;

  logic         clk = 1'b0;
  logic         rst, start, cfg_we, e_op;
  logic [5:0]   op_en;
  logic [2:0]   cfg_idx;
  logic [127:0] cfg_data;
  logic         s_op, busy, done, err;
  logic [2:0]   op;
  logic [31:0]  tx_i, ty_i, x_mem_i, y_mem_i;

  logic [127:0] model_tab [6];
  int           n_tests = 0;
  int           n_fail  = 0;

  dma_op_sequencer #(
    .N_OPS(6), .GAP_CYC(GAP), .SOP_CYC(SOP), .TO_CYC(TB_TO)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .op_en(op_en),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_data(cfg_data), .e_op(e_op),
    .s_op(s_op), .op(op), .tx_i(tx_i), .ty_i(ty_i), .x_mem_i(x_mem_i),
    .y_mem_i(y_mem_i), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "bench timeout");
  end

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic cfg_write(input int idx, input logic [127:0] data);
    cfg_we   = 1'b1;
    cfg_idx  = 3'(idx);
    cfg_data = data;
    tick();
    cfg_we = 1'b0;
    if (idx < 6) model_tab[idx] = data;
  endtask

  task automatic check_desc(input int slot);
    logic [127:0] m;
    m = model_tab[slot];
    check("tx_i", tx_i, m[31:0]);
    check("x_mem_i", x_mem_i, m[63:32]);
    check("ty_i", ty_i, m[95:64]);
    check("y_mem_i", y_mem_i, m[127:96]);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_s_op"}, s_op, 0);
    check({tag, "_op"}, op, 0);
    check({tag, "_tx"}, tx_i, 0);
    check({tag, "_ty"}, ty_i, 0);
    check({tag, "_xmem"}, x_mem_i, 0);
    check({tag, "_ymem"}, y_mem_i, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
  endtask

  // One sequence: start at cycle 0, act as the DMA, check every issue and done.
  // hold: e_op raised during ISSUE and held into WAIT, then a fresh edge later.
  // inject: start + cfg_we to slot 5 at cycle 5 (busy, must be ignored).
  // abort_k: reset during WAIT of the abort_k-th issued op. silent: DMA never ends.
  task automatic run_seq(input logic [5:0] en, input int dly_lo, input int dly_hi,
                         input bit hold, input bit inject, input int abort_k,
                         input bit silent);
    int exp_ops[$];
    int k = 0;
    int cyc, sop_t = -1000, sop_len = 0, dly = 0, last_end = -1, exp_done, end_cyc;
    bit prev_sop = 1'b0, finished = 1'b0, aborted = 1'b0;
    for (int i = 0; i < 6; i++) if (en[i]) exp_ops.push_back(i);
    op_en = en;
    start = 1'b1;
    tick();
    start = 1'b0;
    op_en = 6'($urandom);
    cyc = 1;
    check("busy_rise", busy, 1);
    check("err_clear", err, 0);
    while (cyc < 3000) begin
      if (s_op && !prev_sop) begin
        check("sop_cycle", cyc, (k == 0) ? 1 + GAP : last_end + 2 + GAP);
        if (k < exp_ops.size()) begin
          check("op", op, exp_ops[k]);
          check_desc(exp_ops[k]);
        end else begin
          check("extra_sop", k, exp_ops.size());
        end
        sop_t   = cyc;
        sop_len = 0;
        dly     = $urandom_range(dly_hi, dly_lo);
        k++;
      end
      if (!s_op && prev_sop) check("sop_len", sop_len, SOP);
      if (s_op) sop_len++;
      prev_sop = s_op;
      if (done) begin
        if (silent)                 exp_done = sop_t + SOP + TB_TO;
        else if (exp_ops.size() == 0) exp_done = 2;
        else                        exp_done = last_end + 2;
        check("done_cycle", cyc, exp_done);
        check("ops_issued", k, silent ? 1 : exp_ops.size());
        check("busy_at_done", busy, 1);
        check("err_at_done", err, silent);
        finished = 1'b1;
        break;
      end
      // DMA model
      end_cyc = hold ? sop_t + dly + 2 : sop_t + dly;
      e_op = 1'b0;
      if (!silent && k > 0 && k <= exp_ops.size()) begin
        if (hold) e_op = ((cyc > sop_t) && (cyc < sop_t + dly)) || (cyc == end_cyc);
        else      e_op = (cyc == end_cyc);
        if (cyc == end_cyc) begin
          last_end = cyc;
          check("op_stable", op, exp_ops[k-1]);
        end
      end
      start  = 1'b0;
      cfg_we = 1'b0;
      if (inject && cyc == 5) begin
        start    = 1'b1;
        cfg_we   = 1'b1;
        cfg_idx  = 3'd5;
        cfg_data = rand128();
      end
      if (abort_k >= 0 && k == abort_k + 1 && cyc == sop_t + 5) begin
        #1 rst = 1'b0;
        #1;
        check_all_zero("abort");
        for (int i = 0; i < 6; i++) model_tab[i] = '0;
        e_op  = 1'b0;
        start = 1'b0;
        #2 rst = 1'b1;
        aborted = 1'b1;
        break;
      end
      tick();
      cyc++;
    end
    if (!aborted) begin
      check("done_seen", finished, 1);
      e_op   = 1'b0;
      start  = 1'b0;
      cfg_we = 1'b0;
      tick();
      check("busy_fall", busy, 0);
      check("done_pulse", done, 0);
    end
  endtask

  initial begin
    rst      = 1'b0;
    start    = 1'b0;
    cfg_we   = 1'b0;
    cfg_idx  = '0;
    cfg_data = '0;
    e_op     = 1'b0;
    op_en    = '0;
    for (int i = 0; i < 6; i++) model_tab[i] = '0;
    #3;
    check_all_zero("reset");
    #10 rst = 1'b1;
    tick();
    tick();

    // Reference tile descriptors, packed {y_mem, ty, x_mem, tx}.
    cfg_write(0, rand128());
    cfg_write(1, {32'd392, 32'd15, 32'd14, 32'd15});
    cfg_write(2, {32'd0, 32'd37, 32'd144, 32'd37});
    cfg_write(3, {32'd0, 32'd1, 32'd18, 32'd19});
    cfg_write(4, {32'd0, 32'd1, 32'd324, 32'd37});
    cfg_write(5, {32'd0, 32'd1, 32'd0, 32'd1});
    cfg_write(6, rand128());
    cfg_write(7, rand128());

    run_seq(6'b111111, 10, 10, 0, 0, -1, 0);
    run_seq(6'b100010, 10, 10, 0, 0, -1, 0);
    run_seq(6'b000000, 10, 10, 0, 0, -1, 0);
    run_seq(6'b001010, 8, 8, 1, 0, -1, 0);
    run_seq(6'b111111, 3, 12, 0, 1, -1, 0);
    run_seq(6'b100000, 3, 5, 0, 0, -1, 0);

    for (int r = 0; r < 8; r++) begin
      repeat ($urandom_range(3, 0)) cfg_write($urandom_range(7, 0), rand128());
      run_seq(6'($urandom), 3, 14, 0, 0, -1, 0);
      repeat ($urandom_range(2, 0)) tick();
    end

    run_seq(6'b111111, 8, 12, 0, 0, 3, 0);
    tick();
    run_seq(6'b111111, 3, 8, 0, 0, -1, 0);

`ifdef DMA_SEQ_TIMEOUT_EN
    run_seq(6'b000010, 10, 10, 0, 0, -1, 1);
    repeat (3) tick();
    check("err_sticky", err, 1);
    run_seq(6'b000011, 4, 6, 0, 0, -1, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
